// File: rtl/hazard_unit_dual_if.sv
// Pipeline-side signal bundle for the dual-issue hazard/forwarding unit.
// master = pipeline (drives register fields), slave = hazard_unit_dual.
interface hazard_unit_dual_if;
  logic [4:0] rs_d_0, rs_d_1, rt_d_0, rt_d_1;
  logic [4:0] writereg_d_0;
  logic       regwrite_d_0;
  logic       startmult_d_0, startmult_d_1;
  logic [4:0] rs_e_0, rs_e_1, rt_e_0, rt_e_1;
  logic [4:0] writereg_e_0, writereg_e_1;
  logic       regwrite_e_0, regwrite_e_1;
  logic       memtoreg_e_0, memtoreg_e_1;
  logic       startmult_e_0, startmult_e_1;
  logic [4:0] writereg_m_0, writereg_m_1;
  logic       regwrite_m_0, regwrite_m_1;
  logic [4:0] writereg_w_0, writereg_w_1;
  logic       regwrite_w_0, regwrite_w_1;
  logic [2:0] forwarda_e_0, forwarda_e_1, forwardb_e_0, forwardb_e_1;
  logic       stall_f, stall_d, flush_e;
  logic [1:0] issue_d;

  modport master (
    output rs_d_0, rs_d_1, rt_d_0, rt_d_1, writereg_d_0, regwrite_d_0,
           startmult_d_0, startmult_d_1,
           rs_e_0, rs_e_1, rt_e_0, rt_e_1, writereg_e_0, writereg_e_1,
           regwrite_e_0, regwrite_e_1, memtoreg_e_0, memtoreg_e_1,
           startmult_e_0, startmult_e_1,
           writereg_m_0, writereg_m_1, regwrite_m_0, regwrite_m_1,
           writereg_w_0, writereg_w_1, regwrite_w_0, regwrite_w_1,
    input  forwarda_e_0, forwarda_e_1, forwardb_e_0, forwardb_e_1,
           stall_f, stall_d, flush_e, issue_d
  );

  modport slave (
    input  rs_d_0, rs_d_1, rt_d_0, rt_d_1, writereg_d_0, regwrite_d_0,
           startmult_d_0, startmult_d_1,
           rs_e_0, rs_e_1, rt_e_0, rt_e_1, writereg_e_0, writereg_e_1,
           regwrite_e_0, regwrite_e_1, memtoreg_e_0, memtoreg_e_1,
           startmult_e_0, startmult_e_1,
           writereg_m_0, writereg_m_1, regwrite_m_0, regwrite_m_1,
           writereg_w_0, writereg_w_1, regwrite_w_0, regwrite_w_1,
    output forwarda_e_0, forwarda_e_1, forwardb_e_0, forwardb_e_1,
           stall_f, stall_d, flush_e, issue_d
  );
endinterface

// File: rtl/hazard_unit_dual.sv
// Dual-issue hazard/forwarding controller: forward selects, load-use and bundle-split stalls.
// Optional multiplier interlock enabled by defining HAZARD_MULT_INTERLOCK_EN.
//
// state | meaning
// IDLE  | both decode slots pending issue
// SPLIT | slot 0 already issued, slot 1 pending
module hazard_unit_dual #(
  parameter int MULT_LAT = 4
) (
  input logic                clk,
  input logic                reset,
  hazard_unit_dual_if.slave  hz
);

  typedef enum logic {IDLE, SPLIT} state_t;

  state_t state, state_nx;
  logic   lu, mb, dep, slot0_pending;
  logic   ld_e_0, ld_e_1;

  // M beats W; within a stage the younger slot 1 wins.
  function automatic logic [2:0] fwd_sel(
    input logic [4:0] src,
    input logic       rw_m1, input logic [4:0] wr_m1,
    input logic       rw_m0, input logic [4:0] wr_m0,
    input logic       rw_w1, input logic [4:0] wr_w1,
    input logic       rw_w0, input logic [4:0] wr_w0
  );
    logic [2:0] sel;
    sel = 3'b000;
    if (src != 5'd0) begin
      if (rw_m1 && wr_m1 == src)      sel = 3'b110;
      else if (rw_m0 && wr_m0 == src) sel = 3'b010;
      else if (rw_w1 && wr_w1 == src) sel = 3'b101;
      else if (rw_w0 && wr_w0 == src) sel = 3'b001;
    end
    return sel;
  endfunction

  always_comb begin
    hz.forwarda_e_0 = fwd_sel(hz.rs_e_0, hz.regwrite_m_1, hz.writereg_m_1, hz.regwrite_m_0,
                              hz.writereg_m_0, hz.regwrite_w_1, hz.writereg_w_1,
                              hz.regwrite_w_0, hz.writereg_w_0);
    hz.forwardb_e_0 = fwd_sel(hz.rt_e_0, hz.regwrite_m_1, hz.writereg_m_1, hz.regwrite_m_0,
                              hz.writereg_m_0, hz.regwrite_w_1, hz.writereg_w_1,
                              hz.regwrite_w_0, hz.writereg_w_0);
    hz.forwarda_e_1 = fwd_sel(hz.rs_e_1, hz.regwrite_m_1, hz.writereg_m_1, hz.regwrite_m_0,
                              hz.writereg_m_0, hz.regwrite_w_1, hz.writereg_w_1,
                              hz.regwrite_w_0, hz.writereg_w_0);
    hz.forwardb_e_1 = fwd_sel(hz.rt_e_1, hz.regwrite_m_1, hz.writereg_m_1, hz.regwrite_m_0,
                              hz.writereg_m_0, hz.regwrite_w_1, hz.writereg_w_1,
                              hz.regwrite_w_0, hz.writereg_w_0);
  end

  // Only slots still waiting for issue can be hit by a load or multiplier hazard.
  assign slot0_pending = (state == IDLE);
  assign ld_e_0 = hz.memtoreg_e_0 & hz.regwrite_e_0 & (hz.writereg_e_0 != 5'd0);
  assign ld_e_1 = hz.memtoreg_e_1 & hz.regwrite_e_1 & (hz.writereg_e_1 != 5'd0);

  always_comb begin
    lu = 1'b0;
    if (ld_e_0 && ((slot0_pending && (hz.writereg_e_0 == hz.rs_d_0 || hz.writereg_e_0 == hz.rt_d_0))
                   || hz.writereg_e_0 == hz.rs_d_1 || hz.writereg_e_0 == hz.rt_d_1))
      lu = 1'b1;
    if (ld_e_1 && ((slot0_pending && (hz.writereg_e_1 == hz.rs_d_0 || hz.writereg_e_1 == hz.rt_d_0))
                   || hz.writereg_e_1 == hz.rs_d_1 || hz.writereg_e_1 == hz.rt_d_1))
      lu = 1'b1;
  end

  assign dep = hz.regwrite_d_0 & (hz.writereg_d_0 != 5'd0) &
               ((hz.rs_d_1 == hz.writereg_d_0) | (hz.rt_d_1 == hz.writereg_d_0));

`ifdef HAZARD_MULT_INTERLOCK_EN
  logic [3:0] mcnt;

  // A multiply flushed out of E never started, so it must not arm the counter.
  always_ff @(posedge clk) begin
    if (reset)
      mcnt <= 4'd0;
    else if ((hz.startmult_e_0 | hz.startmult_e_1) && !hz.flush_e)
      mcnt <= 4'(MULT_LAT - 1);
    else if (mcnt != 4'd0)
      mcnt <= mcnt - 4'd1;
  end

  assign mb = (mcnt != 4'd0) & ((slot0_pending & hz.startmult_d_0) | hz.startmult_d_1);
`else
  logic unused_mult;
  assign unused_mult = ^{hz.startmult_d_0, hz.startmult_d_1, hz.startmult_e_0, hz.startmult_e_1};
  assign mb = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx   = state;
    hz.stall_f = 1'b0;
    hz.stall_d = 1'b0;
    hz.flush_e = 1'b0;
    hz.issue_d = 2'b11;
    if (lu || mb) begin
      hz.stall_f = 1'b1;
      hz.stall_d = 1'b1;
      hz.flush_e = 1'b1;
      hz.issue_d = 2'b00;
    end else begin
      case (state)
        IDLE: begin
          if (dep) begin
            hz.issue_d = 2'b01;
            hz.stall_f = 1'b1;
            hz.stall_d = 1'b1;
            state_nx   = SPLIT;
          end
        end
        SPLIT: begin
          hz.issue_d = 2'b10;
          state_nx   = IDLE;
        end
        default: state_nx = IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_hazard_unit_dual.sv
// Directed bench for hazard_unit_dual: expected output vectors queued per step, checked at negedge.
module tb_hazard_unit_dual;

`ifdef HAZARD_MULT_INTERLOCK_EN
  localparam bit MI = 1'b1;
`else
  localparam bit MI = 1'b0;
`endif

  // {fa0, fb0, fa1, fb1, stall_f, stall_d, flush_e, issue_d}
  localparam logic [16:0] E_RUN    = {12'd0, 3'b000, 2'b11};
  localparam logic [16:0] E_LU     = {12'd0, 3'b111, 2'b00};
  localparam logic [16:0] E_SPLIT0 = {12'd0, 3'b110, 2'b01};
  localparam logic [16:0] E_SPLIT1 = {12'd0, 3'b000, 2'b10};
  localparam logic [16:0] E_MUL    = MI ? E_LU : E_RUN;

  logic clk = 1'b0;
  logic reset;
  int   n_run = 0;
  int   n_fail = 0;
  string       tag_q[$];
  logic [16:0] exp_q[$];

  always #5 clk = ~clk;

  hazard_unit_dual_if hif();
  hazard_unit_dual #(.MULT_LAT(4)) dut (.clk(clk), .reset(reset), .hz(hif));

  function automatic logic [16:0] fw(input logic [2:0] fa0, fb0, fa1, fb1);
    return {fa0, fb0, fa1, fb1, 3'b000, 2'b11};
  endfunction

  task automatic clear_all();
    hif.rs_d_0 = 0; hif.rs_d_1 = 0; hif.rt_d_0 = 0; hif.rt_d_1 = 0;
    hif.writereg_d_0 = 0; hif.regwrite_d_0 = 0;
    hif.startmult_d_0 = 0; hif.startmult_d_1 = 0;
    hif.rs_e_0 = 0; hif.rs_e_1 = 0; hif.rt_e_0 = 0; hif.rt_e_1 = 0;
    hif.writereg_e_0 = 0; hif.writereg_e_1 = 0;
    hif.regwrite_e_0 = 0; hif.regwrite_e_1 = 0;
    hif.memtoreg_e_0 = 0; hif.memtoreg_e_1 = 0;
    hif.startmult_e_0 = 0; hif.startmult_e_1 = 0;
    hif.writereg_m_0 = 0; hif.writereg_m_1 = 0; hif.regwrite_m_0 = 0; hif.regwrite_m_1 = 0;
    hif.writereg_w_0 = 0; hif.writereg_w_1 = 0; hif.regwrite_w_0 = 0; hif.regwrite_w_1 = 0;
  endtask

  task automatic clear_e();
    hif.memtoreg_e_0 = 0; hif.memtoreg_e_1 = 0; hif.regwrite_e_0 = 0; hif.regwrite_e_1 = 0;
    hif.writereg_e_0 = 0; hif.writereg_e_1 = 0;
  endtask

  task automatic set_dep();
    hif.regwrite_d_0 = 1; hif.writereg_d_0 = 3; hif.rt_d_1 = 3;
  endtask

  task automatic step(input string tag, input logic [16:0] e);
    logic [16:0] act;
    string       t;
    logic [16:0] x;
    tag_q.push_back(tag);
    exp_q.push_back(e);
    @(negedge clk);
    while (exp_q.size() != 0) begin
      t = tag_q.pop_front();
      x = exp_q.pop_front();
      act = {hif.forwarda_e_0, hif.forwardb_e_0, hif.forwarda_e_1, hif.forwardb_e_1,
             hif.stall_f, hif.stall_d, hif.flush_e, hif.issue_d};
      n_run++;
      assert (act === x) else begin
        n_fail++;
        $error("FAIL %s: observed %h expected %h", t, act, x);
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    clear_all();
    tick();
    reset = 1'b0;
    step("reset_state", E_RUN);

    // forwarding priority
    hif.regwrite_m_1 = 1; hif.writereg_m_1 = 5; hif.regwrite_w_0 = 1; hif.writereg_w_0 = 5;
    hif.rs_e_0 = 5;
    step("fwd_m1_over_w0", fw(3'b110, 3'b000, 3'b000, 3'b000));
    hif.regwrite_m_1 = 0; hif.regwrite_m_0 = 1; hif.writereg_m_0 = 5;
    hif.regwrite_w_1 = 1; hif.writereg_w_1 = 5; hif.rt_e_1 = 5;
    step("fwd_m0_over_w", fw(3'b010, 3'b000, 3'b000, 3'b010));
    hif.regwrite_m_0 = 0; hif.rt_e_0 = 5; hif.rs_e_1 = 5;
    step("fwd_w1_over_w0", fw(3'b101, 3'b101, 3'b101, 3'b101));
    hif.regwrite_w_1 = 0;
    step("fwd_w0", fw(3'b001, 3'b001, 3'b001, 3'b001));
    clear_all();
    hif.writereg_m_1 = 5; hif.rs_e_0 = 5;
    step("fwd_needs_regwrite", E_RUN);
    clear_all();
    hif.regwrite_m_0 = 1; hif.writereg_m_0 = 0; hif.regwrite_w_1 = 1; hif.writereg_w_1 = 0;
    step("fwd_reg0", E_RUN);
    clear_all();

    // load-use
    hif.memtoreg_e_0 = 1; hif.regwrite_e_0 = 1; hif.writereg_e_0 = 7; hif.rs_d_1 = 7;
    step("lu_e0_rs_d1", E_LU);
    clear_e();
    step("lu_release", E_RUN);
    clear_all();
    hif.memtoreg_e_1 = 1; hif.regwrite_e_1 = 1; hif.writereg_e_1 = 9; hif.rt_d_0 = 9;
    step("lu_e1_rt_d0", E_LU);
    clear_all();
    hif.memtoreg_e_0 = 1; hif.regwrite_e_0 = 1; hif.writereg_e_0 = 0;
    step("lu_reg0_none", E_RUN);
    clear_all();
    hif.memtoreg_e_1 = 1; hif.regwrite_e_1 = 0; hif.writereg_e_1 = 6; hif.rs_d_1 = 6;
    step("lu_no_regwrite", E_RUN);
    hif.memtoreg_e_1 = 0; hif.regwrite_e_1 = 1;
    step("lu_not_load", E_RUN);
    clear_all();

    // bundle split
    set_dep();
    step("split_n", E_SPLIT0);
    step("split_n1", E_SPLIT1);
    step("split_n2_idle", E_SPLIT0);
    clear_all();
    step("split_n3", E_SPLIT1);
    step("split_done", E_RUN);
    hif.regwrite_d_0 = 1; hif.writereg_d_0 = 0;
    step("dep_reg0_none", E_RUN);
    hif.regwrite_d_0 = 0; hif.writereg_d_0 = 3; hif.rs_d_1 = 3;
    step("dep_no_regwrite", E_RUN);
    clear_all();

    // load-use while split: only slot 1 counts
    set_dep();
    step("split_a", E_SPLIT0);
    hif.memtoreg_e_0 = 1; hif.regwrite_e_0 = 1; hif.writereg_e_0 = 4; hif.rs_d_0 = 4;
    step("split_lu_slot0_ignored", E_SPLIT1);
    clear_all();
    set_dep();
    step("split_b", E_SPLIT0);
    hif.memtoreg_e_0 = 1; hif.regwrite_e_0 = 1; hif.writereg_e_0 = 3;
    step("split_lu_slot1", E_LU);
    clear_e();
    step("split_after_lu", E_SPLIT1);
    clear_all();
    step("split_b_done", E_RUN);

    // load-use wins over dep and holds IDLE
    set_dep();
    hif.memtoreg_e_1 = 1; hif.regwrite_e_1 = 1; hif.writereg_e_1 = 3;
    step("lu_over_dep", E_LU);
    clear_e();
    step("dep_after_lu", E_SPLIT0);
    clear_all();
    step("dep_after_lu_2", E_SPLIT1);
    step("dep_after_lu_3", E_RUN);

    // multiplier interlock
    hif.startmult_e_0 = 1; hif.startmult_d_1 = 1;
    step("mul_start", E_RUN);
    hif.startmult_e_0 = 0;
    step("mul_n1", E_MUL);
    step("mul_n2", E_MUL);
    step("mul_n3", E_MUL);
    step("mul_n4_release", E_RUN);
    clear_all();
    hif.startmult_e_0 = 1;
    step("mul_reload_a", E_RUN);
    hif.startmult_e_0 = 0;
    step("mul_reload_b", E_RUN);
    hif.startmult_e_1 = 1;
    step("mul_reload_c", E_RUN);
    hif.startmult_e_1 = 0; hif.startmult_d_0 = 1;
    step("mul_reload_n3", E_MUL);
    step("mul_reload_n4", E_MUL);
    step("mul_reload_n5", E_MUL);
    step("mul_reload_release", E_RUN);
    clear_all();
    hif.memtoreg_e_0 = 1; hif.regwrite_e_0 = 1; hif.writereg_e_0 = 7; hif.rs_d_0 = 7;
    hif.startmult_e_1 = 1;
    step("mul_flushed_start", E_LU);
    clear_all();
    hif.startmult_d_0 = 1;
    step("mul_flushed_no_load", E_RUN);
    clear_all();

    // reset during split with multiplier busy
    hif.startmult_e_0 = 1;
    step("rst_mul_start", E_RUN);
    clear_all();
    set_dep();
    step("rst_split", E_SPLIT0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    clear_all();
    hif.startmult_d_1 = 1;
    step("rst_idle_mcnt0", E_RUN);
    clear_all();

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule

// File: doc/hazard_unit_dual.md
# hazard_unit_dual

Dual-issue hazard and forwarding controller: the source side of the execute stage's forwarding selects. It drives the 3-bit `forwarda_e_*`/`forwardb_e_*` codes that the execute stage decodes, and it generates fetch/decode stalls, execute flushes and per-slot issue masks. The issue masks cover load-use hazards, intra-bundle dependencies (bundle split) and multiplier occupancy. It sits beside the pipeline registers and observes the decode, execute, memory and writeback register fields of both slots.

## Interface
- `MULT_LAT`, 4: multiplier occupancy in cycles, including the start cycle; legal range 2..15.
- `clk` in 1: pipeline clock.
- `reset` in 1: synchronous, active-high.
- `rs_d_0/1`, `rt_d_0/1` in 5: decode-stage source registers.
- `writereg_d_0`, `regwrite_d_0` in 5/1: decode slot-0 destination register and its write enable.
- `startmult_d_0/1` in 1: decode-stage instruction starts a multiply.
- `rs_e_0/1`, `rt_e_0/1` in 5: execute-stage source registers.
- `writereg_e_0/1`, `regwrite_e_0/1`, `memtoreg_e_0/1` in 5/1/1: execute-stage destination register, write enable, and load flag.
- `startmult_e_0/1` in 1: execute-stage multiply start.
- `writereg_m_0/1`, `regwrite_m_0/1` in 5/1: memory-stage destination register and write enable.
- `writereg_w_0/1`, `regwrite_w_0/1` in 5/1: writeback-stage destination register and write enable.
- `forwarda_e_0/1`, `forwardb_e_0/1` out 3: forwarding select codes.
- `stall_f`, `stall_d` out 1: hold the PC and the decode register.
- `flush_e` out 1: load bubble into the execute register.
- `issue_d` out 2: per-slot valid into the execute register; bit0 is slot 0.

## Operation
- Forward codes, combinational, evaluated per operand:
  - 3'b110: `execout_m_1`.
  - 3'b010: `execout_m_0`.
  - 3'b101: `result_w_1`.
  - 3'b001: `result_w_0`.
  - 3'b000: register file.
  - Priority: M over W. Within a stage, slot 1 over slot 0 (slot 1 is younger).
  - A match requires the matching `regwrite` and a source register != 0. Register 0 always yields 3'b000.
- Load-use hazard (`lu`):
  - Condition: for either E slot, `memtoreg_e_x & regwrite_e_x & writereg_e_x != 0`, and `writereg_e_x` equals any `rs_d`/`rt_d` of a slot still to be issued.
  - Response: `stall_f`=1, `stall_d`=1, `flush_e`=1, `issue_d`=2'b00.
- Intra-bundle dependency (`dep`):
  - Condition: `regwrite_d_0 & writereg_d_0 != 0 & (rs_d_1 == writereg_d_0 | rt_d_1 == writereg_d_0)`.
- FSM with states IDLE and SPLIT:
  - IDLE with `lu`: apply the load-use response and stay in IDLE.
  - IDLE with `dep`: `issue_d`=2'b01, `stall_f`=`stall_d`=1, next state SPLIT.
  - IDLE otherwise: `issue_d`=2'b11, no stall.
  - SPLIT with `lu` (checked against slot 1 only): apply the load-use response and stay in SPLIT.
  - SPLIT otherwise: `issue_d`=2'b10, no stall, next state IDLE.
- Multiplier interlock (`mb`):
  - 4-bit counter `mcnt`. It loads `MULT_LAT-1` when `startmult_e_0|startmult_e_1` and `flush_e`=0. Otherwise it decrements while nonzero.
  - `mb` = `mcnt != 0` and a to-be-issued D slot has `startmult_d`. Response is identical to the load-use response.
- Priority: `lu`/`mb` over `dep`. A stalled cycle never advances the FSM.

## Timing
- Forward codes and stall/flush/issue outputs are combinational from the inputs, the FSM state and `mcnt`, with zero latency.
- State and `mcnt` update on the `clk` rising edge.
- Reset values:
  - State IDLE, `mcnt`=0.
  - With all inputs 0: `forward*`=3'b000, `stall_f`=`stall_d`=`flush_e`=0, `issue_d`=2'b11.
- `reset` asserted mid-split or mid-multiply: IDLE and `mcnt`=0 after that edge. The outputs in the reset cycle itself are don't-care.
- Split costs exactly 1 extra cycle. A load-use stall costs 1 cycle per occurrence. A multiplier stall lasts until `mcnt` reaches 0.
- Back-to-back multiplies in E reload the counter; no accumulation.

## Configuration
- `HAZARD_MULT_INTERLOCK_EN` defined: `mcnt` and the `mb` stall are present as specified.
- Not defined: no counter, `mb`=0, and `startmult_*` inputs are ignored. The multiplier is then assumed single-cycle or software-scheduled.

## Test plan
- `regwrite_m_1`=1, `writereg_m_1`=5; `regwrite_w_0`=1, `writereg_w_0`=5; `rs_e_0`=5 -> `forwarda_e_0`=3'b110.
- `rt_e_1`=0 with `writereg_m_0`=0 and `regwrite_m_0`=1 -> `forwardb_e_1`=3'b000.
- `memtoreg_e_0`=1, `regwrite_e_0`=1, `writereg_e_0`=7; `rs_d_1`=7 -> `stall_f`=`stall_d`=`flush_e`=1, `issue_d`=00. Next cycle, with E cleared -> `issue_d`=11.
- `regwrite_d_0`=1, `writereg_d_0`=3, `rt_d_1`=3 -> cycle N: `issue_d`=01 with stall. Cycle N+1: `issue_d`=10, no stall. Cycle N+2: IDLE.
- Macro on, `MULT_LAT`=4: `startmult_e_0` pulse at cycle N, `startmult_d_1`=1 held -> stall asserted in cycles N+1..N+3, released at N+4. Macro off -> no stall.
- `reset` asserted in the SPLIT state -> next cycle `issue_d`=11, `mcnt`=0.
